// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd: 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core with separate imem/dmem and program-load/debug ports.
// Define MIPS32_FWD_EN for EX forwarding with a 1-cycle load-use stall; otherwise ID interlocks on EX/MEM writers.
module mips32_pipe_fwd #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    localparam int IA = $clog2(IMEM_DEPTH),
    localparam int DA = $clog2(DMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [IA-1:0]   imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    input  logic [DA-1:0]   dbg_maddr,
    output logic [XLEN-1:0] dbg_mdata,
    output logic [IA-1:0]   pc,
    output logic            halted,
    output logic [31:0]     retired
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    typedef struct packed {
        logic       rd_rs;
        logic       rd_rt;
        logic       we;
        logic [4:0] dst;
        logic       hlt;
    } dec_t;

    // Unknown opcodes decode as HLT; we is only set for a non-zero destination.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d = '0;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                d.rd_rs = 1'b1;
                d.rd_rt = 1'b1;
                d.dst   = ir[15:11];
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                d.rd_rs = 1'b1;
                d.dst   = ir[20:16];
            end
            OP_SW: begin
                d.rd_rs = 1'b1;
                d.rd_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: d.rd_rs = 1'b1;
            default: d.hlt = 1'b1;
        endcase
        d.we = (d.dst != 5'd0);
        return d;
    endfunction

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] regs [32];

    logic            ifid_valid;
    logic [31:0]     ifid_ir;
    logic [IA-1:0]   ifid_npc;

    logic            idex_valid;
    logic [5:0]      idex_op;
    logic [4:0]      idex_dst;
    logic            idex_we;
    logic            idex_hlt;
    logic [XLEN-1:0] idex_a;
    logic [XLEN-1:0] idex_b;
    logic [XLEN-1:0] idex_imm;
    logic [IA-1:0]   idex_npc;
`ifdef MIPS32_FWD_EN
    logic [4:0]      idex_rs;
    logic [4:0]      idex_rt;
`endif

    logic            exmem_valid;
    logic [5:0]      exmem_op;
    logic [4:0]      exmem_dst;
    logic            exmem_we;
    logic            exmem_hlt;
    logic [XLEN-1:0] exmem_res;
    logic [XLEN-1:0] exmem_sd;

    logic            memwb_valid;
    logic [4:0]      memwb_dst;
    logic            memwb_we;
    logic            memwb_hlt;
    logic [XLEN-1:0] memwb_res;

    // ID: decode and register read with WB write-through
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    dec_t            id_dec;
    logic [XLEN+15:0] id_imm_w;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_a;
    logic [XLEN-1:0] id_b;
    logic            wb_we;

    assign id_rs    = ifid_ir[25:21];
    assign id_rt    = ifid_ir[20:16];
    assign id_dec   = decode(ifid_ir);
    assign id_imm_w = {{XLEN{ifid_ir[15]}}, ifid_ir[15:0]};
    assign id_imm   = id_imm_w[XLEN-1:0];
    assign wb_we    = memwb_valid && memwb_we;

    assign id_a = (id_rs == 5'd0) ? '0 :
                  (wb_we && memwb_dst == id_rs) ? memwb_res : regs[id_rs];
    assign id_b = (id_rt == 5'd0) ? '0 :
                  (wb_we && memwb_dst == id_rt) ? memwb_res : regs[id_rt];

    // Hazard detection
    logic id_need_ex;
    logic stall;
    logic fetch_freeze;

    assign id_need_ex = idex_valid && idex_we &&
                        ((id_dec.rd_rs && id_rs == idex_dst) || (id_dec.rd_rt && id_rt == idex_dst));

`ifdef MIPS32_FWD_EN
    assign stall = ifid_valid && id_need_ex && (idex_op == OP_LW);
`else
    logic id_need_mem;
    assign id_need_mem = exmem_valid && exmem_we &&
                         ((id_dec.rd_rs && id_rs == exmem_dst) || (id_dec.rd_rt && id_rt == exmem_dst));
    assign stall = ifid_valid && (id_need_ex || id_need_mem);
`endif

    // Any HLT in ID or later keeps fetch frozen until it retires or is flushed.
    assign fetch_freeze = (ifid_valid && id_dec.hlt) || (idex_valid && idex_hlt) ||
                          (exmem_valid && exmem_hlt) || (memwb_valid && memwb_hlt);

    // EX: operand selection, ALU and branch resolution
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_res;
    logic            ex_taken;
    logic [IA-1:0]   ex_target;

`ifdef MIPS32_FWD_EN
    // A load in EX/MEM has no data yet; the load-use stall guarantees it is never needed from there.
    always_comb begin
        ex_a = idex_a;
        if (exmem_valid && exmem_we && exmem_op != OP_LW && exmem_dst == idex_rs)
            ex_a = exmem_res;
        else if (wb_we && memwb_dst == idex_rs)
            ex_a = memwb_res;
        ex_b = idex_b;
        if (exmem_valid && exmem_we && exmem_op != OP_LW && exmem_dst == idex_rt)
            ex_b = exmem_res;
        else if (wb_we && memwb_dst == idex_rt)
            ex_b = memwb_res;
    end
`else
    assign ex_a = idex_a;
    assign ex_b = idex_b;
`endif

    always_comb begin
        ex_res = '0;
        case (idex_op)
            OP_ADD:                ex_res = ex_a + ex_b;
            OP_SUB:                ex_res = ex_a - ex_b;
            OP_AND:                ex_res = ex_a & ex_b;
            OP_OR:                 ex_res = ex_a | ex_b;
            OP_SLT:                ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_MUL:                ex_res = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + idex_imm;
            OP_SUBI:               ex_res = ex_a - idex_imm;
            OP_SLTI:               ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(idex_imm))};
            default:               ex_res = '0;
        endcase
    end

    assign ex_taken  = idex_valid && ((idex_op == OP_BEQZ && ex_a == '0) ||
                                      (idex_op == OP_BNEQZ && ex_a != '0));
    assign ex_target = idex_npc + idex_imm[IA-1:0];

    // Pipeline registers; everything freezes once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            halted      <= 1'b0;
            retired     <= '0;
            ifid_valid  <= 1'b0;
            idex_valid  <= 1'b0;
            exmem_valid <= 1'b0;
            memwb_valid <= 1'b0;
        end else if (!halted) begin
            if (ex_taken) begin
                pc         <= ex_target;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                if (fetch_freeze) begin
                    ifid_valid <= 1'b0;
                end else begin
                    pc         <= pc + IA'(1);
                    ifid_valid <= 1'b1;
                    ifid_ir    <= imem[pc];
                    ifid_npc   <= pc + IA'(1);
                end
            end

            if (ex_taken || stall) begin
                idex_valid <= 1'b0;
            end else begin
                idex_valid <= ifid_valid;
                idex_op    <= ifid_ir[31:26];
                idex_dst   <= id_dec.dst;
                idex_we    <= id_dec.we;
                idex_hlt   <= id_dec.hlt;
                idex_a     <= id_a;
                idex_b     <= id_b;
                idex_imm   <= id_imm;
                idex_npc   <= ifid_npc;
`ifdef MIPS32_FWD_EN
                idex_rs    <= id_rs;
                idex_rt    <= id_rt;
`endif
            end

            exmem_valid <= idex_valid;
            exmem_op    <= idex_op;
            exmem_dst   <= idex_dst;
            exmem_we    <= idex_we;
            exmem_hlt   <= idex_hlt;
            exmem_res   <= ex_res;
            exmem_sd    <= ex_b;

            memwb_valid <= exmem_valid;
            memwb_dst   <= exmem_dst;
            memwb_we    <= exmem_we;
            memwb_hlt   <= exmem_hlt;
            memwb_res   <= (exmem_op == OP_LW) ? dmem[exmem_res[DA-1:0]] : exmem_res;

            if (memwb_valid)
                retired <= retired + 32'd1;
            if (memwb_valid && memwb_hlt)
                halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (!halted && wb_we) begin
            regs[memwb_dst] <= memwb_res;
        end
    end

    // A store in MEM at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && !halted && exmem_valid && exmem_op == OP_SW)
            dmem[exmem_res[DA-1:0]] <= exmem_sd;
    end

    always_ff @(posedge clk) begin
        if (imem_we && (rst || halted))
            imem[imem_waddr] <= imem_wdata;
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
    assign dbg_mdata = dmem[dbg_maddr];

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// Directed-program bench for mips32_pipe_fwd: driver loads/runs programs, monitor checks a queue of
// expected register/memory/counter values whenever the core halts or an immediate check is requested.
`timescale 1ns/100ps
module tb_mips32_pipe_fwd;

    localparam int XLEN = 32;
    localparam int IA   = 10;
    localparam int DA   = 10;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [31:0] HLT     = 32'hFC00_0000;
    localparam logic [31:0] UNDEF   = 32'hF800_0000;

    localparam int K_REG  = 0;
    localparam int K_MEM  = 1;
    localparam int K_RET  = 2;
    localparam int K_PC   = 3;
    localparam int K_HALT = 4;
    localparam int K_CYC  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_we = 1'b0;
    logic [IA-1:0]   imem_waddr = '0;
    logic [31:0]     imem_wdata = '0;
    logic [4:0]      dbg_raddr = '0;
    logic [XLEN-1:0] dbg_rdata;
    logic [DA-1:0]   dbg_maddr = '0;
    logic [XLEN-1:0] dbg_mdata;
    logic [IA-1:0]   pc;
    logic            halted;
    logic [31:0]     retired;

    mips32_pipe_fwd #(.XLEN(XLEN), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .dbg_maddr  (dbg_maddr),
        .dbg_mdata  (dbg_mdata),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired)
    );

    // Clock and cycle counter (edges since reset release up to and including the halting edge)
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (rst)
            cyc <= 0;
        else if (!halted)
            cyc <= cyc + 1;
    end

    // Scoreboard state
    logic [31:0] exp_q[$];
    int          kind_q[$];
    int          idx_q[$];
    string       tag_q[$];
    logic [31:0] prog[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    bit          arm_now = 1'b0;
    bit          arm_halt = 1'b0;

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Driver tasks
    task automatic put(input logic [31:0] w);
        prog.push_back(w);
    endtask

    task automatic load_prog();
        rst = 1'b1;
        foreach (prog[i]) begin
            imem_we    = 1'b1;
            imem_waddr = IA'(i);
            imem_wdata = prog[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
        prog.delete();
        @(negedge clk);
    endtask

    task automatic expect_val(input int k, input int ix, input logic [31:0] v, input string tag);
        exp_q.push_back(v);
        kind_q.push_back(k);
        idx_q.push_back(ix);
        tag_q.push_back(tag);
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        bit ok;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt != start)
                ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: no check within %0d cycles (halted=%0d, pc=%0d), required a halt/check", name, budget, halted, pc);
            exp_q.delete();
            kind_q.delete();
            idx_q.delete();
            tag_q.delete();
            arm_now  = 1'b0;
            arm_halt = 1'b0;
        end
    endtask

    task automatic run_to_halt(input int budget, input string name);
        rst      = 1'b0;
        arm_halt = 1'b1;
        wait_done(budget, name);
    endtask

    task automatic check_now(input string name);
        arm_now = 1'b1;
        wait_done(4, name);
    endtask

    // Monitor: drains the expected queue once the core presents a result (halt) or on request.
    initial begin : monitor
        logic [31:0] e;
        logic [31:0] act;
        int          k;
        int          ix;
        string       tag;
        forever begin
            @(negedge clk);
            if (arm_now || (arm_halt && halted)) begin
                while (exp_q.size() > 0) begin
                    e   = exp_q.pop_front();
                    k   = kind_q.pop_front();
                    ix  = idx_q.pop_front();
                    tag = tag_q.pop_front();
                    act = '0;
                    case (k)
                        K_REG: begin dbg_raddr = ix[4:0]; #0.5; act = dbg_rdata; end
                        K_MEM: begin dbg_maddr = ix[DA-1:0]; #0.5; act = dbg_mdata; end
                        K_RET:  act = retired;
                        K_PC:   act = 32'(pc);
                        K_HALT: act = 32'(halted);
                        default: act = 32'(cyc);
                    endcase
                    total++;
                    if (act !== e) begin
                        bad++;
                        $display("FAIL %s: got 0x%08h required 0x%08h", tag, act, e);
                    end
                end
                arm_now  = 1'b0;
                arm_halt = 1'b0;
                done_cnt++;
            end
        end
    end

    // Stimulus
    initial begin : driver
        @(negedge clk);

        // ALU chain; reset state checked while rst is still held after loading
        put(ri(OP_ADDI, 1, 0, 5));
        put(ri(OP_ADDI, 2, 1, 7));
        put(rr(OP_ADD, 3, 1, 2));
        put(rr(OP_MUL, 4, 3, 2));
        put(HLT);
        load_prog();
        expect_val(K_PC,   0, 32'd0, "reset_pc");
        expect_val(K_HALT, 0, 32'd0, "reset_halted");
        expect_val(K_RET,  0, 32'd0, "reset_retired");
        expect_val(K_REG,  1, 32'd0, "reset_r1");
        check_now("reset_state");

        expect_val(K_REG,  1, 32'd5,   "chain_r1");
        expect_val(K_REG,  2, 32'd12,  "chain_r2");
        expect_val(K_REG,  3, 32'd17,  "chain_r3");
        expect_val(K_REG,  4, 32'd204, "chain_r4");
        expect_val(K_REG,  0, 32'd0,   "chain_r0");
        expect_val(K_RET,  0, 32'd5,   "chain_retired");
        expect_val(K_HALT, 0, 32'd1,   "chain_halted");
`ifdef MIPS32_FWD_EN
        expect_val(K_CYC,  0, 32'd9,   "chain_cycles");
`else
        expect_val(K_CYC,  0, 32'd15,  "chain_cycles");
`endif
        run_to_halt(200, "chain_halt");

        // Load-use: SW data forwarded, LW result consumed immediately
        put(ri(OP_ADDI, 3, 0, 17));
        put(ri(OP_SW, 3, 0, 0));
        put(ri(OP_LW, 5, 0, 0));
        put(rr(OP_ADD, 6, 5, 5));
        put(HLT);
        load_prog();
        expect_val(K_MEM, 0, 32'd17, "lu_dmem0");
        expect_val(K_REG, 5, 32'd17, "lu_r5");
        expect_val(K_REG, 6, 32'd34, "lu_r6");
        expect_val(K_RET, 0, 32'd5,  "lu_retired");
`ifdef MIPS32_FWD_EN
        expect_val(K_CYC, 0, 32'd10, "lu_cycles");
`else
        expect_val(K_CYC, 0, 32'd13, "lu_cycles");
`endif
        run_to_halt(200, "lu_halt");

        // Loop: BNEQZ taken twice, the HLT behind it is cancelled each time
        put(ri(OP_ADDI, 1, 0, 3));
        put(ri(OP_SUBI, 1, 1, 1));
        put(ri(OP_BNEQZ, 0, 1, -2));
        put(HLT);
        load_prog();
        expect_val(K_REG, 1, 32'd0, "loop_r1");
        expect_val(K_RET, 0, 32'd8, "loop_retired");
        run_to_halt(300, "loop_halt");

        // Flush: shadow ADDI and HLT skipped, fetch resumes at target 3
        put(ri(OP_BEQZ, 0, 0, 2));
        put(ri(OP_ADDI, 7, 0, 9));
        put(HLT);
        put(ri(OP_ADDI, 8, 0, 4));
        put(HLT);
        load_prog();
        expect_val(K_REG, 7, 32'd0, "flush_r7");
        expect_val(K_REG, 8, 32'd4, "flush_r8");
        expect_val(K_RET, 0, 32'd3, "flush_retired");
        run_to_halt(200, "flush_halt");

        // Signed compare, wrap-around and undefined opcode acting as HLT
        put(ri(OP_ADDI, 1, 0, -1));
        put(ri(OP_SLTI, 2, 1, 0));
        put(ri(OP_ADDI, 3, 1, 1));
        put(UNDEF);
        put(ri(OP_ADDI, 4, 0, 5));
        load_prog();
        expect_val(K_REG, 1, 32'hFFFF_FFFF, "sign_r1");
        expect_val(K_REG, 2, 32'd1,         "sign_r2");
        expect_val(K_REG, 3, 32'd0,         "sign_r3");
        expect_val(K_REG, 4, 32'd0,         "undef_r4");
        expect_val(K_RET, 0, 32'd4,         "undef_retired");
        run_to_halt(200, "undef_halt");

        // imem write while running must be ignored
        put(ri(OP_ADDI, 1, 0, 20));
        put(ri(OP_SUBI, 1, 1, 1));
        put(ri(OP_BNEQZ, 0, 1, -2));
        put(HLT);
        load_prog();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        imem_we    = 1'b1;
        imem_waddr = IA'(3);
        imem_wdata = ri(OP_ADDI, 9, 0, 77);
        @(negedge clk);
        imem_we = 1'b0;
        expect_val(K_REG, 9, 32'd0,  "imemwr_r9");
        expect_val(K_REG, 1, 32'd0,  "imemwr_r1");
        expect_val(K_RET, 0, 32'd42, "imemwr_retired");
        arm_halt = 1'b1;
        wait_done(2000, "imemwr_halt");

        // rst mid-loop returns to the reset state
        put(ri(OP_ADDI, 1, 0, 20));
        put(ri(OP_SUBI, 1, 1, 1));
        put(ri(OP_BNEQZ, 0, 1, -2));
        put(HLT);
        load_prog();
        rst = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_val(K_PC,   0, 32'd0, "midrst_pc");
        expect_val(K_RET,  0, 32'd0, "midrst_retired");
        expect_val(K_HALT, 0, 32'd0, "midrst_halted");
        expect_val(K_REG,  1, 32'd0, "midrst_r1");
        check_now("midrst_state");

        // Program reloaded during rst: remaining ALU ops plus store/load round trip
        put(ri(OP_ADDI, 1, 0, -3));
        put(ri(OP_ADDI, 2, 0, 10));
        put(rr(OP_SUB, 3, 2, 1));
        put(rr(OP_AND, 4, 3, 2));
        put(rr(OP_OR, 5, 3, 2));
        put(rr(OP_SLT, 6, 1, 2));
        put(rr(OP_SLT, 7, 2, 1));
        put(ri(OP_SW, 5, 2, 4));
        put(ri(OP_LW, 8, 0, 14));
        put(HLT);
        load_prog();
        expect_val(K_REG, 1, 32'hFFFF_FFFD, "reload_r1");
        expect_val(K_REG, 3, 32'd13, "reload_sub");
        expect_val(K_REG, 4, 32'd8,  "reload_and");
        expect_val(K_REG, 5, 32'd15, "reload_or");
        expect_val(K_REG, 6, 32'd1,  "reload_slt_lt");
        expect_val(K_REG, 7, 32'd0,  "reload_slt_ge");
        expect_val(K_MEM, 14, 32'd15, "reload_dmem14");
        expect_val(K_REG, 8, 32'd15, "reload_lw");
        expect_val(K_RET, 0, 32'd10, "reload_retired");
        run_to_halt(300, "reload_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
